latch_bank: RTL and testbench
=============================

# latch_bank

Parametrised, double-buffered successor to the single-bit `latch`. It holds CHANNELS independent WIDTH-bit registers. Writes go one channel at a time into a shadow stage, and a single `commit` strobe moves every pending channel to the outputs on the same clock edge. Channels that change together therefore update atomically. The block sits between a configuration/control source and downstream datapath logic that must never see a half-updated set of values.

## Interface
- `WIDTH`, 8, data width per channel (≥1)
- `CHANNELS`, 4, number of channels (≥1)
- `SEL_W`, 2, select width; must satisfy 2^SEL_W ≥ CHANNELS
- `COUNT_W`, 8, width of the commit counter

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `load`  in  1  write strobe for the shadow stage
- `sel`  in  SEL_W  target channel index for `load`
- `data`  in  WIDTH  write data
- `commit`  in  1  transfer all pending shadows to the outputs
- `out`  out  CHANNELS*WIDTH  committed values, flattened; channel k occupies bits [k*WIDTH +: WIDTH]
- `pending`  out  CHANNELS  per-channel flag: shadow written since that channel's last commit
- `done`  out  1  one-cycle pulse after an effective commit
- `err`  out  1  one-cycle pulse after a `load` with `sel` ≥ CHANNELS
- `commit_count`  out  COUNT_W  number of effective commits, modulo 2^COUNT_W

## Operation
- Each channel k has a shadow register `shadow[k]`, a committed register (its slice of `out`) and a `pending[k]` flag.
- **Load, `load`=1 and `sel` < CHANNELS:**
  - `shadow[sel]` ← `data`; `pending[sel]` ← 1.
  - Reloading a channel that is already pending overwrites its shadow; last write wins.
- **Load, `load`=1 and `sel` ≥ CHANNELS:**
  - No state changes.
  - `err` = 1 for the next cycle.
- **Commit, `commit`=1:**
  - For every k with `pending[k]`=1 (value before the edge): `out[k]` ← `shadow[k]` and `pending[k]` ← 0.
  - Channels that are not pending hold their `out` value.
- **Effective commit:** `commit`=1 while at least one `pending` bit is set.
  - `commit_count` increments by 1, wrapping from 2^COUNT_W−1 to 0.
  - `done` = 1 for the next cycle.
- **Empty commit:** `commit` with no pending bits is a no-op. No `done`, no count change.
- **Simultaneous `load` and `commit` in one cycle:**
  - The commit uses pre-edge shadows and pending flags.
  - The load is then applied, so the loaded channel ends with the new shadow and `pending`=1.
  - If that channel was already pending, its old shadow is committed to `out`, then overwritten in the shadow stage. It stays pending.
  - The load never reaches `out` in the same cycle.
- **Consecutive commits:** back-to-back `commit` cycles are allowed. Only the first is effective unless a load arrived in between.
- The block has no combinational path from any input to any output.

## Timing
- **Reset** (`rst`=1 at an edge):
  - All shadows, `out`, `pending`, `commit_count`, `done` and `err` become 0.
  - Reset overrides `load` and `commit` in the same cycle.
  - Reset mid-sequence discards all pending shadow data.
- **Latencies:**
  - `load` → `pending` high: 1 cycle.
  - `load` → value visible on `out`: ≥2 cycles (load edge, then commit edge).
  - `commit` → `out`, `pending` clear, `done`, `commit_count`: all on the same edge, 1 cycle.
- `done` and `err` are single-cycle pulses. They are high for exactly one cycle per triggering event, including back-to-back events.
- **Throughput:** one load and one commit accepted every cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `load`=1, `commit`=1, `data`=8'hFF.
  - → `out`=0, `pending`=0, `commit_count`=0, `done`=0, `err`=0.
- **Staged write, then commit** (CHANNELS=4, WIDTH=8):
  - Load ch0=8'hA5, then ch2=8'h3C. → `pending`=4'b0101; `out` still 0.
  - Commit. → `out`=32'h003C00A5, `pending`=0, `done` pulse, `commit_count`=1.
- **Partial commit holds others:**
  - Load ch1=8'h11 and commit.
  - → ch1=8'h11; ch0 and ch2 unchanged (8'hA5, 8'h3C); `commit_count`=2.
- **Simultaneous load and commit:**
  - With ch3 pending at 8'h77, assert `load` ch3=8'h99 together with `commit`.
  - → ch3 `out`=8'h77, `pending[3]`=1.
  - A following commit gives ch3=8'h99.
- **Error and empty commit:**
  - With CHANNELS=3 and SEL_W=2, load `sel`=3. → `err` pulse; no state change.
  - Commit with `pending`=0. → no `done`, count unchanged.
- **Counter wrap and reset mid-operation:**
  - With COUNT_W=2, perform 4 effective commits. → `commit_count` goes 1, 2, 3, 0.
  - Load ch0 and assert `rst` in the next cycle. → `pending`=0; a later commit changes nothing.

Source files
------------

// File: rtl/latch_bank.sv
// Double-buffered bank of CHANNELS WIDTH-bit registers. Loads are staged
// per channel in shadow registers; one commit strobe publishes every pending channel at once.
module latch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int COUNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [SEL_W-1:0]          sel,
    input  logic [WIDTH-1:0]          data,
    input  logic                      commit,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       pending,
    output logic                      done,
    output logic                      err,
    output logic [COUNT_W-1:0]        commit_count
);

    // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

    logic sel_ok;
    logic load_ok;
    logic eff_commit;

    assign sel_ok     = ({1'b0, sel} < CH_LIM);
    assign load_ok    = load & sel_ok;
    assign eff_commit = commit & (|pending);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic             hit;
        logic             pend_r;
        logic [WIDTH-1:0] shadow_r;
        logic [WIDTH-1:0] out_r;

        assign hit = load_ok && (sel == SEL_W'(k));

        // Commit consumes the pre-edge shadow; a same-cycle load then refills
        // the shadow and keeps the channel pending.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend_r   <= 1'b0;
                shadow_r <= '0;
                out_r    <= '0;
            end else begin
                if (commit && pend_r) begin
                    out_r <= shadow_r;
                end
                if (hit) begin
                    shadow_r <= data;
                    pend_r   <= 1'b1;
                end else if (commit) begin
                    pend_r <= 1'b0;
                end
            end
        end

        assign pending[k]              = pend_r;
        assign out[k*WIDTH +: WIDTH]   = out_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done         <= 1'b0;
            err          <= 1'b0;
            commit_count <= '0;
        end else begin
            done <= eff_commit;
            err  <= load & ~sel_ok;
            if (eff_commit) begin
                commit_count <= commit_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_latch_bank.sv
// Bench for latch_bank: a 4-channel instance and a 3-channel / 2-bit-counter
// instance share stimulus; both are checked against a behavioural model.
module tb_latch_bank;

    logic        clk = 1'b0;
    logic        rst, load, commit;
    logic [1:0]  sel;
    logic [7:0]  data;

    logic [31:0] out4;
    logic [3:0]  pend4;
    logic        done4, err4;
    logic [7:0]  cnt4;

    logic [23:0] out3;
    logic [2:0]  pend3;
    logic        done3, err3;
    logic [1:0]  cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: index 0 = 4-channel instance, index 1 = 3-channel instance.
    int m_sh   [2][4];
    int m_out  [2][4];
    bit m_pd   [2][4];
    int m_cnt  [2];
    bit m_done [2];
    bit m_err  [2];

    latch_bank #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .load(load), .sel(sel), .data(data), .commit(commit),
        .out(out4), .pending(pend4), .done(done4), .err(err4), .commit_count(cnt4)
    );

    latch_bank #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .COUNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .load(load), .sel(sel), .data(data), .commit(commit),
        .out(out3), .pending(pend3), .done(done3), .err(err3), .commit_count(cnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        load;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic        commit;
        logic [31:0] exp_out;
        logic [3:0]  exp_pend;
        logic        exp_done;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int nch(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int cmod(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    task automatic model_step(input int i);
        bit any;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_sh[i][k] = 0; m_out[i][k] = 0; m_pd[i][k] = 0;
            end
            m_cnt[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end else begin
            any = 0;
            for (int k = 0; k < nch(i); k++) if (m_pd[i][k]) any = 1;
            for (int k = 0; k < nch(i); k++) begin
                if (commit && m_pd[i][k]) begin
                    m_out[i][k] = m_sh[i][k];
                    m_pd[i][k]  = 0;
                end
            end
            m_done[i] = commit && any;
            if (m_done[i]) m_cnt[i] = (m_cnt[i] + 1) % cmod(i);
            m_err[i] = load && (int'(sel) >= nch(i));
            if (load && int'(sel) < nch(i)) begin
                m_sh[i][sel] = int'(data);
                m_pd[i][sel] = 1;
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] eo, ep;
        logic [63:0] ao, ap, ad, ae, ac;
        for (int i = 0; i < 2; i++) begin
            eo = '0; ep = '0;
            for (int k = 0; k < nch(i); k++) begin
                eo = eo | (64'(m_out[i][k]) << (8 * k));
                ep[k] = m_pd[i][k];
            end
            ao = (i == 0) ? 64'(out4)  : 64'(out3);
            ap = (i == 0) ? 64'(pend4) : 64'(pend3);
            ad = (i == 0) ? 64'(done4) : 64'(done3);
            ae = (i == 0) ? 64'(err4)  : 64'(err3);
            ac = (i == 0) ? 64'(cnt4)  : 64'(cnt3);
            chk($sformatf("model_out[%0d]", i),     ao, eo);
            chk($sformatf("model_pending[%0d]", i), ap, ep);
            chk($sformatf("model_done[%0d]", i),    ad, 64'(m_done[i]));
            chk($sformatf("model_err[%0d]", i),     ae, 64'(m_err[i]));
            chk($sformatf("model_count[%0d]", i),   ac, 64'(m_cnt[i]));
        end
    endtask

    // Drive at the falling edge, clock once, then compare at the next falling edge.
    task automatic apply(input logic r, input logic l, input logic [1:0] s,
                         input logic [7:0] d, input logic c);
        rst = r; load = l; sel = s; data = d; commit = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; commit = 1'b0; sel = '0; data = '0;

        //            rst  load sel   data   com  out            pend     done cnt
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 1'b1, 32'h00000000, 4'b0000, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 1'b1, 32'h00000000, 4'b0000, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 8'hA5, 1'b0, 32'h00000000, 4'b0001, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 2'd2, 8'h3C, 1'b0, 32'h00000000, 4'b0101, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h003C00A5, 4'b0000, 1'b1, 8'd1};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'h11, 1'b0, 32'h003C00A5, 4'b0010, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h003C11A5, 4'b0000, 1'b1, 8'd2};
        vecs[7]  = '{1'b0, 1'b1, 2'd3, 8'h77, 1'b0, 32'h003C11A5, 4'b1000, 1'b0, 8'd2};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 8'h99, 1'b1, 32'h773C11A5, 4'b1000, 1'b1, 8'd3};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h993C11A5, 4'b0000, 1'b1, 8'd4};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h993C11A5, 4'b0000, 1'b0, 8'd4};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 32'h993C11A5, 4'b0000, 1'b0, 8'd4};

        @(negedge clk);
        for (int v = 0; v < 12; v++) begin
            apply(vecs[v].rst, vecs[v].load, vecs[v].sel, vecs[v].data, vecs[v].commit);
            chk($sformatf("vec%0d_out", v),     64'(out4),  64'(vecs[v].exp_out));
            chk($sformatf("vec%0d_pending", v), 64'(pend4), 64'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_done", v),    64'(done4), 64'(vecs[v].exp_done));
            chk($sformatf("vec%0d_err", v),     64'(err4),  64'(1'b0));
            chk($sformatf("vec%0d_count", v),   64'(cnt4),  64'(vecs[v].exp_cnt));
        end

        // Out-of-range select on the 3-channel instance, then an empty commit.
        apply(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        apply(1'b0, 1'b1, 2'd3, 8'hAA, 1'b0);
        chk("err_pulse",    64'(err3),  64'(1'b1));
        chk("err_no_pend",  64'(pend3), 64'(3'b000));
        chk("err_no_out",   64'(out3),  64'(24'h0));
        apply(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        chk("err_cleared",  64'(err3),  64'(1'b0));
        chk("empty_done",   64'(done3), 64'(1'b0));
        chk("empty_count",  64'(cnt3),  64'(2'd0));

        // Two-bit counter wraps after four effective commits.
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 2'(i % 3), 8'(8'h10 + i), 1'b0);
            apply(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
            chk($sformatf("wrap_count%0d", i), 64'(cnt3), 64'((i + 1) % 4));
            chk($sformatf("wrap_done%0d", i),  64'(done3), 64'(1'b1));
        end
        chk("wrap_out", 64'(out3), 64'(24'h121113));

        // Reset right after a load throws the staged value away.
        apply(1'b0, 1'b1, 2'd0, 8'h55, 1'b0);
        chk("pre_rst_pend", 64'(pend3), 64'(3'b001));
        apply(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("rst_pend",  64'(pend3), 64'(3'b000));
        chk("rst_count", 64'(cnt3),  64'(2'd0));
        apply(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        chk("rst_commit_out",  64'(out3),  64'(24'h0));
        chk("rst_commit_done", 64'(done3), 64'(1'b0));

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 1) == 1),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
